// File: rtl/ssd_scan_driver.sv
// Time-multiplexed 4-digit seven-segment driver with frame-boundary double buffering.
// Optional leading-zero suppression is enabled by defining SSD_LZ_BLANK_EN.
module ssd_scan_driver #(
    parameter int SCAN_DIV  = 18,
    parameter int BLANK_CYC = 256
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [15:0] digits_in,
    input  logic [3:0]  dp_in,
    input  logic [3:0]  blank_in,
    input  logic        load,
    output logic [3:0]  An,
    output logic [7:0]  Cath,
    output logic        frame_done
);

    localparam logic [SCAN_DIV-1:0] BLANK_LIM = SCAN_DIV'(BLANK_CYC);
    localparam logic [SCAN_DIV-1:0] PRE_TERM  = ~(SCAN_DIV'(1));

    logic [SCAN_DIV-1:0] presc;
    logic [1:0]          idx;

    logic [15:0] act_digits, pend_digits;
    logic [3:0]  act_dp, pend_dp;
    logic [3:0]  act_blank, pend_blank;
    logic        pend_valid;

    logic        term;
    logic        wrap;
    logic        fd_next;
    logic        in_blank;
    logic [3:0]  cur_digit;
    logic [3:0]  lz;
    logic [3:0]  dark;

    function automatic logic [6:0] seg7(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0:    s = 7'b0000001;
            4'h1:    s = 7'b1001111;
            4'h2:    s = 7'b0010010;
            4'h3:    s = 7'b0000110;
            4'h4:    s = 7'b1001100;
            4'h5:    s = 7'b0100100;
            4'h6:    s = 7'b0100000;
            4'h7:    s = 7'b0001111;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0000100;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b1100000;
            4'hC:    s = 7'b0110001;
            4'hD:    s = 7'b1000010;
            4'hE:    s = 7'b0110000;
            default: s = 7'b0111000;
        endcase
        return s;
    endfunction

    always_comb begin
        term      = &presc;
        wrap      = term && (idx == 2'd3);
        // frame_done is registered, so it is raised one cycle early to coincide with the wrap cycle
        fd_next   = (presc == PRE_TERM) && (idx == 2'd3);
        in_blank  = presc < BLANK_LIM;
        cur_digit = act_digits[{idx, 2'b00} +: 4];
`ifdef SSD_LZ_BLANK_EN
        lz[3] = (act_digits[15:12] == 4'h0) && !act_dp[3];
        lz[2] = lz[3] && (act_digits[11:8] == 4'h0) && !act_dp[2];
        lz[1] = lz[2] && (act_digits[7:4] == 4'h0) && !act_dp[1];
        lz[0] = 1'b0;
`else
        lz = '0;
`endif
        dark = act_blank | lz;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            presc       <= '0;
            idx         <= '0;
            act_digits  <= '0;
            act_dp      <= '0;
            act_blank   <= '1;
            pend_digits <= '0;
            pend_dp     <= '0;
            pend_blank  <= '1;
            pend_valid  <= 1'b0;
            An          <= '1;
            Cath        <= '1;
            frame_done  <= 1'b0;
        end else begin
            presc      <= presc + 1'b1;
            if (term)
                idx <= idx + 2'd1;
            frame_done <= fd_next;
            An         <= (in_blank || dark[idx]) ? 4'b1111 : ~(4'b0001 << idx);
            Cath       <= {seg7(cur_digit), ~act_dp[idx]};

            // A load coinciding with the frame wrap bypasses the pending set
            if (wrap) begin
                if (load) begin
                    act_digits <= digits_in;
                    act_dp     <= dp_in;
                    act_blank  <= blank_in;
                end else if (pend_valid) begin
                    act_digits <= pend_digits;
                    act_dp     <= pend_dp;
                    act_blank  <= pend_blank;
                end
                pend_valid <= 1'b0;
            end else if (load) begin
                pend_digits <= digits_in;
                pend_dp     <= dp_in;
                pend_blank  <= blank_in;
                pend_valid  <= 1'b1;
            end
        end
    end

endmodule
